// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display-channel scheduler.
package disp_sched_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DWELL  = 2'd1,
        MANUAL = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rr_next_ch.sv
// Combinational round-robin finder over the channel mask.
// incl=1 searches from cur itself; incl=0 searches strictly after cur and
// only lands back on cur when cur is the sole set bit.
module rr_next_ch
    import disp_sched_pkg::*;
(
    input  logic [CH_W-1:0]   cur,
    input  logic [NUM_CH-1:0] mask,
    input  logic              incl,
    output logic [CH_W-1:0]   nxt,
    output logic              found
);

    logic [CH_W-1:0] idx;

    // Walk the eight positions starting at cur (or cur+1), wrapping 7->0,
    // and keep the first one whose mask bit is set.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = cur;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = cur + CH_W'(i) + (incl ? CH_W'(0) : CH_W'(1));
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_chan_sched.sv
// Round-robin display-channel scheduler driving the 8x32 display mux select.
// Optional build macro: DISP_SCHED_SKIP_EN -- when defined, only requesting
// channels are visited; when undefined, req is ignored and all 8 channels
// are visited in order.
module disp_chan_sched
    import disp_sched_pkg::*;
#(
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int CNT_W        = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              manual,
    input  logic [CH_W-1:0]   sel_in,
    input  logic [NUM_CH-1:0] req,
    input  logic              next,
    output logic [CH_W-1:0]   sel,
    output logic              sel_valid,
    output logic              switch_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    sched_state_e      state_q, state_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic              valid_q, valid_d;
    logic              pulse_q, pulse_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_CH-1:0] mask;
    logic              curDropped;
    logic              searchIncl;
    logic [CH_W-1:0]   rrNxt;
    logic              rrFound;
    logic              advance;

`ifdef DISP_SCHED_SKIP_EN
    assign mask       = req;
    assign curDropped = ~req[sel_q];
`else
    logic unusedReq;
    assign unusedReq  = ^req;
    assign mask       = {NUM_CH{1'b1}};
    assign curDropped = 1'b0;
`endif

    // Leaving IDLE may land on the current channel; advancing from DWELL
    // must move past it.
    assign searchIncl = (state_q == IDLE);

    rr_next_ch uRrNext (
        .cur   (sel_q),
        .mask  (mask),
        .incl  (searchIncl),
        .nxt   (rrNxt),
        .found (rrFound)
    );

    // Any single advance reason, or several at once, yields one step.
    assign advance = (cnt_q == CNT_LAST) || next || curDropped;

    // Next-state logic: en=0 freezes everything, manual beats any advance,
    // and the strobe fires on a changed sel or a rising sel_valid.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (manual) begin
                        state_d = MANUAL;
                        sel_d   = sel_in;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else if (rrFound) begin
                        state_d = DWELL;
                        sel_d   = rrNxt;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                DWELL: begin
                    if (manual) begin
                        state_d = MANUAL;
                        sel_d   = sel_in;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else if (advance) begin
                        cnt_d = '0;
                        if (rrFound) begin
                            sel_d = rrNxt;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MANUAL: begin
                    cnt_d = '0;
                    if (manual) begin
                        sel_d   = sel_in;
                        valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
            pulse_d = (sel_d != sel_q) || (valid_d && !valid_q);
        end
    end

    // State, select, valid, strobe and dwell counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel          = sel_q;
    assign sel_valid    = valid_q;
    assign switch_pulse = pulse_q;

endmodule
